frame_update_arbiter: RTL and testbench

- Shares the single game-state/object-RAM update port between N requesters (player, bug movers, score logic).
- Grants access only during vertical blanking, derived from the H/V coordinate counter outputs (H, V, endFrame).
- Round-robin arbitration with a req/gnt/done handshake; each requester is serviced at most once per frame.
- Sits between the H/V coordinate generator and the game-logic blocks.

---
 rtl/frame_update_arbiter_if.sv | 28 ++
 rtl/frame_update_arbiter.sv | 149 ++++++++++++++
 tb/tb_frame_update_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_update_arbiter_if.sv
// Bundle of the H/V timing inputs and the req/gnt/done handshake shared by
// the frame update arbiter and the game-logic requesters.
interface frame_update_arbiter_if #(
  parameter int N_REQ = 4
) ();

  logic [14:0]      H;
  logic [14:0]      V;
  logic             endFrame;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] gnt;
  logic             busy;
  logic [N_REQ-1:0] served;
  logic [15:0]      frame_cnt;
  logic             overrun;

  modport master (
    output H, V, endFrame, req, done,
    input  gnt, busy, served, frame_cnt, overrun
  );

  modport slave (
    input  H, V, endFrame, req, done,
    output gnt, busy, served, frame_cnt, overrun
  );

endinterface

// File: rtl/frame_update_arbiter.sv
// Round-robin arbiter for the shared game-state/object-RAM update port.
// Grants are only issued during vertical blanking, at most once per requester per frame.
module frame_update_arbiter #(
  parameter int N_REQ    = 4,
  parameter int V_ACTIVE = 480,
  parameter int MAX_HOLD = 64
) (
  input logic                   clk,
  input logic                   rst_n,
  frame_update_arbiter_if.slave bus
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD);

  typedef enum logic [0:0] {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] served_q, served_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic             window;
  logic [N_REQ-1:0] eligible;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand_idx;
  logic             pick_found;
  logic             release_now;
  logic             force_release;
  int               cand;
  logic             unused_h;

  assign window   = (bus.V >= 15'(V_ACTIVE)) && !bus.endFrame;
  assign eligible = bus.req & ~served_q;
  assign unused_h = ^bus.H;

  // First eligible requester at or after the round-robin pointer, wrapping at N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!pick_found && eligible[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    served_d      = served_q;
    busy_d        = busy_q;
    overrun_d     = overrun_q;
    frame_cnt_d   = frame_cnt_q;
    rr_d          = rr_q;
    idx_d         = idx_q;
    hold_d        = hold_q;
    release_now   = 1'b0;
    force_release = 1'b0;

    case (state_q)
      IDLE: begin
        if (window && pick_found) begin
          state_d = GRANT;
          gnt_d   = N_REQ'(1) << pick_idx;
          busy_d  = 1'b1;
          idx_d   = pick_idx;
          hold_d  = '0;
        end
      end
      GRANT: begin
        hold_d = hold_q + 1'b1;
        // A clean finish outranks both window close and timeout.
        if (bus.done[idx_q] || !bus.req[idx_q]) begin
          release_now = 1'b1;
        end else if (!window || (hold_q == HOLD_W'(MAX_HOLD - 1))) begin
          release_now   = 1'b1;
          force_release = 1'b1;
        end
        if (release_now) begin
          state_d          = IDLE;
          gnt_d            = '0;
          busy_d           = 1'b0;
          hold_d           = '0;
          served_d[idx_q]  = 1'b1;
          rr_d             = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        end
        if (force_release) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    // Frame boundary wipes the served set even if a release lands on the same edge.
    if (bus.endFrame) begin
      served_d    = '0;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      served_q    <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      rr_q        <= '0;
      idx_q       <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      served_q    <= served_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      rr_q        <= rr_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.served    = served_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_frame_update_arbiter.sv
// Randomized and directed bench for frame_update_arbiter, compared each cycle
// against a behavioural model of the per-frame round-robin grant rules.
module tb_frame_update_arbiter;

  localparam int N  = 4;
  localparam int VA = 480;
  localparam int MH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  frame_update_arbiter_if #(.N_REQ(N)) bus ();

  frame_update_arbiter #(
    .N_REQ(N),
    .V_ACTIVE(VA),
    .MAX_HOLD(MH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: current grantee (-1 when none), its grant age, served set, rr pointer.
  int          m_cur;
  int          m_age;
  int          m_rr;
  logic [N-1:0] m_served;
  logic [15:0] m_frames;
  logic        m_overrun;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_cur     = -1;
    m_age     = 0;
    m_rr      = 0;
    m_served  = '0;
    m_frames  = '0;
    m_overrun = 1'b0;
  endtask

  task automatic model_step();
    bit win;
    bit rel;
    int k;
    win = (int'(bus.V) >= VA) && !bus.endFrame;
    rel = 1'b0;
    if (m_cur >= 0) begin
      if (bus.done[m_cur] || !bus.req[m_cur]) begin
        rel = 1'b1;
      end else if (!win || m_age == MH - 1) begin
        rel = 1'b1;
        m_overrun = 1'b1;
      end
      if (rel) begin
        m_served[m_cur] = 1'b1;
        m_rr  = (m_cur + 1) % N;
        m_cur = -1;
      end else begin
        m_age++;
      end
    end else if (win) begin
      for (int i = 0; i < N; i++) begin
        k = (m_rr + i) % N;
        if (m_cur < 0 && bus.req[k] && !m_served[k]) begin
          m_cur = k;
          m_age = 0;
        end
      end
    end
    if (bus.endFrame) begin
      m_served = '0;
      m_frames = m_frames + 16'd1;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] exp_gnt;
    exp_gnt = (m_cur >= 0) ? (N'(1) << m_cur) : '0;
    check_output("gnt", 32'(bus.gnt), 32'(exp_gnt));
    check_output("busy", 32'(bus.busy), 32'(m_cur >= 0));
    check_output("served", 32'(bus.served), 32'(m_served));
    check_output("frame_cnt", 32'(bus.frame_cnt), 32'(m_frames));
    check_output("overrun", 32'(bus.overrun), 32'(m_overrun));
    check_output("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
  endtask

  task automatic apply_stimulus(input logic [N-1:0] r, input logic [N-1:0] d, input int v, input logic ef);
    bus.req      = r;
    bus.done     = d;
    bus.V        = 15'(v);
    bus.endFrame = ef;
    bus.H        = 15'($urandom);
  endtask

  // Inputs are already set at the falling edge; the model advances with the rising edge.
  task automatic run_cycle(input bit do_check);
    model_step();
    @(posedge clk);
    #1;
    if (do_check) begin
      compare_all();
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    apply_stimulus('0, '0, 0, 1'b0);
    model_reset();
    #1;
    check_output("rst_gnt", 32'(bus.gnt), 32'd0);
    check_output("rst_busy", 32'(bus.busy), 32'd0);
    check_output("rst_served", 32'(bus.served), 32'd0);
    check_output("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    check_output("rst_overrun", 32'(bus.overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int           order[$];
    logic [N-1:0] prev;
    logic [N-1:0] r;
    logic [N-1:0] d;
    int           hi;
    int           v;
    logic         ef;

    apply_stimulus('0, '0, 0, 1'b0);
    model_reset();
    apply_reset();

    // No grant during active video; one clock latency once blanking starts.
    apply_stimulus(4'b0001, '0, 100, 1'b0);
    repeat (50) run_cycle(1);
    check_output("gnt_active_video", 32'(bus.gnt), 32'd0);
    apply_stimulus(4'b0001, '0, 480, 1'b0);
    run_cycle(1);
    check_output("gnt_latency", 32'(bus.gnt), 32'b0001);
    check_output("busy_latency", 32'(bus.busy), 32'd1);

    // All four requesting, each finishing 3 cycles into its grant.
    apply_reset();
    prev = '0;
    for (int c = 0; c < 40; c++) begin
      d = '0;
      if (m_cur >= 0 && m_age == 3) d[m_cur] = 1'b1;
      apply_stimulus(4'b1111, d, 480, 1'b0);
      run_cycle(1);
      if (bus.gnt != '0 && prev == '0) order.push_back($clog2(bus.gnt));
      prev = bus.gnt;
    end
    check_output("order_len", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_output("order", (i < order.size()) ? 32'(order[i]) : 32'hFF, 32'(i));
    end
    check_output("served_all", 32'(bus.served), 32'b1111);
    check_output("no_regrant", 32'(bus.gnt), 32'd0);

    // Frame boundary clears served and the pointer has wrapped back to 0.
    apply_stimulus(4'b1111, '0, 480, 1'b1);
    run_cycle(1);
    check_output("ef_served", 32'(bus.served), 32'd0);
    check_output("ef_frame_cnt", 32'(bus.frame_cnt), 32'd1);
    apply_stimulus(4'b1111, '0, 480, 1'b0);
    run_cycle(1);
    check_output("ef_next_gnt", 32'(bus.gnt), 32'b0001);

    // Requester that never finishes is cut off after MAX_HOLD cycles.
    apply_reset();
    apply_stimulus(4'b0010, '0, 480, 1'b0);
    hi = 0;
    repeat (80) begin
      run_cycle(1);
      if (bus.gnt == 4'b0010) hi++;
    end
    check_output("timeout_len", 32'(hi), 32'(MH));
    check_output("timeout_overrun", 32'(bus.overrun), 32'd1);
    check_output("timeout_served", 32'(bus.served), 32'b0010);

    // Window closes mid-grant, then asynchronous reset mid-grant.
    apply_reset();
    apply_stimulus(4'b0001, '0, 480, 1'b0);
    repeat (3) run_cycle(1);
    check_output("wc_gnt_before", 32'(bus.gnt), 32'b0001);
    apply_stimulus(4'b0001, '0, 0, 1'b0);
    run_cycle(1);
    check_output("wc_gnt_after", 32'(bus.gnt), 32'd0);
    check_output("wc_overrun", 32'(bus.overrun), 32'd1);
    apply_stimulus(4'b0001, '0, 480, 1'b1);
    run_cycle(1);
    apply_stimulus(4'b0001, '0, 480, 1'b0);
    repeat (2) run_cycle(1);
    check_output("mid_gnt", 32'(bus.gnt), 32'b0001);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_output("async_gnt", 32'(bus.gnt), 32'd0);
    check_output("async_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    check_output("async_overrun", 32'(bus.overrun), 32'd0);
    check_output("async_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // frame_cnt wrap, then done on a non-granted bit.
    apply_reset();
    apply_stimulus('0, '0, 100, 1'b1);
    repeat (65535) run_cycle(0);
    check_output("frame_cnt_max", 32'(bus.frame_cnt), 32'hFFFF);
    run_cycle(1);
    check_output("frame_cnt_wrap", 32'(bus.frame_cnt), 32'd0);
    apply_stimulus(4'b0001, '0, 480, 1'b0);
    repeat (2) run_cycle(1);
    apply_stimulus(4'b0001, 4'b0100, 480, 1'b0);
    run_cycle(1);
    check_output("foreign_done_gnt", 32'(bus.gnt), 32'b0001);
    check_output("foreign_done_served", 32'(bus.served), 32'd0);

    // Random traffic against the model.
    apply_reset();
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      d  = ($urandom_range(0, 11) == 0) ? N'($urandom) : '0;
      v  = ($urandom_range(0, 9) < 7) ? (480 + int'($urandom_range(0, 44))) : int'($urandom_range(0, 479));
      ef = ($urandom_range(0, 39) == 0);
      apply_stimulus(r, d, v, ef);
      run_cycle(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
